// File: rtl/multicycle_datapath.sv
// multicycle_datapath
//   Multi-cycle RV32I-subset core. Each instruction walks FETCH/DECODE/EXECUTE
//   and optionally MEM/WRITEBACK under one FSM, so the single ALU and both
//   memories are shared across cycles.
//   Supported: add sub and or slt, addi andi ori, lw sw, beq bne, jal, ecall.
//
//   Parameters
//     XLEN        datapath, register, pc and instret width
//     IMEM_DEPTH  instruction memory words (power of two)
//     DMEM_DEPTH  data memory words (power of two)
//     PC_RESET    pc value loaded by reset
//
//   Ports
//     clk      in   rising-edge clock
//     reset    in   synchronous, active-high
//     pc       out  current program counter
//     state    out  FSM state encoding (see table below)
//     halted   out  high while in HALT
//     instret  out  retired-instruction count
//
//   Build option
//     HALT_ON_ILLEGAL_EN  defined: unknown opcode halts the core with pc on the
//                         offending instruction. Undefined: unknown opcode is a
//                         two-cycle NOP that still retires.
//
//   Internal arrays imem, dmem and regs are preloaded hierarchically and are
//   not cleared by reset.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   FETCH (0)  | IR <= imem[pc]
//   DECODE (1) | read rs1/rs2, form branch/jump target, catch illegal opcode
//   EXECUTE (2)| ALU op / address calc; branches, jal, ecall resolve here
//   MEM (3)    | sw writes dmem and retires; lw captures MDR
//   WRITEBACK(4)| write rd, retire, pc <= pc+4
//   HALT (5)   | absorbing; only reset leaves it

module multicycle_datapath #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256,
  parameter int unsigned PC_RESET   = 0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] pc,
  output logic [2:0]      state,
  output logic            halted,
  output logic [XLEN-1:0] instret
);

  localparam int unsigned IAW = $clog2(IMEM_DEPTH);
  localparam int unsigned DAW = $clog2(DMEM_DEPTH);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] imem [IMEM_DEPTH];
  logic [XLEN-1:0] dmem [DMEM_DEPTH];
  logic [XLEN-1:0] regs [32];

  logic [31:0]     ir;
  logic [XLEN-1:0] a_q, b_q, target_q, alu_q, mdr_q;
  logic [XLEN-1:0] pc_q, instret_q;

  // instruction fields
  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];

  logic is_r, is_i, is_lw, is_sw, is_br, is_jal, is_ecall, illegal;

  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_br    = (opcode == OP_BR);
  assign is_jal   = (opcode == OP_JAL);
  assign is_ecall = (ir == ECALL);
  assign illegal  = !(is_r || is_i || is_lw || is_sw || is_br || is_jal || is_ecall);

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;

  assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  logic [XLEN-1:0] rs1_val, rs2_val;

  // x0 is never written, so its storage is never trusted; force zero on read
  assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];

  // ALU
  logic [XLEN-1:0] alu_b, alu_res;
  logic            slt_bit;

  assign alu_b   = is_r ? b_q : (is_sw ? imm_s : imm_i);
  assign slt_bit = ($signed(a_q) < $signed(alu_b));

  always_comb begin
    alu_res = a_q + alu_b;
    if (is_r || is_i) begin
      case (funct3)
        3'b000:  alu_res = (is_r && ir[30]) ? (a_q - alu_b) : (a_q + alu_b);
        3'b111:  alu_res = a_q & alu_b;
        3'b110:  alu_res = a_q | alu_b;
        3'b010:  alu_res = is_r ? {{(XLEN-1){1'b0}}, slt_bit} : (a_q + alu_b);
        default: alu_res = a_q + alu_b;
      endcase
    end
  end

  logic br_taken;
  // funct3[0] separates bne from beq
  assign br_taken = funct3[0] ? (a_q != b_q) : (a_q == b_q);

  logic [XLEN-1:0] pc_plus4;
  assign pc_plus4 = pc_q + XLEN'(4);

  // control
  logic            pc_en, retire, rf_we, dm_we;
  logic [XLEN-1:0] pc_d, rf_wdata;

  always_comb begin
    state_d  = state_q;
    pc_en    = 1'b0;
    pc_d     = pc_plus4;
    retire   = 1'b0;
    rf_we    = 1'b0;
    rf_wdata = alu_q;
    dm_we    = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (illegal) begin
`ifdef HALT_ON_ILLEGAL_EN
          state_d = S_HALT;
`else
          state_d = S_FETCH;
          pc_en   = 1'b1;
          retire  = 1'b1;
`endif
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (is_r || is_i) begin
          state_d = S_WRITEBACK;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_br) begin
          state_d = S_FETCH;
          pc_en   = 1'b1;
          retire  = 1'b1;
          if (br_taken) pc_d = target_q;
        end else if (is_jal) begin
          state_d  = S_FETCH;
          pc_en    = 1'b1;
          retire   = 1'b1;
          pc_d     = target_q;
          rf_we    = 1'b1;
          rf_wdata = pc_plus4;
        end else begin
          state_d = S_HALT;  // ecall, the only remaining legal class
        end
      end
      S_MEM: begin
        if (is_sw) begin
          state_d = S_FETCH;
          dm_we   = 1'b1;
          pc_en   = 1'b1;
          retire  = 1'b1;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        state_d  = S_FETCH;
        rf_we    = 1'b1;
        rf_wdata = is_lw ? mdr_q : alu_q;
        pc_en    = 1'b1;
        retire   = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= XLEN'(PC_RESET);
      instret_q <= '0;
    end else begin
      if (pc_en)  pc_q      <= pc_d;
      if (retire) instret_q <= instret_q + XLEN'(1);
    end
  end

  // datapath latches; no reset needed, each is written before it is consumed
  always_ff @(posedge clk) begin
    if (state_q == S_FETCH) ir <= imem[pc_q[IAW+1:2]][31:0];
    if (state_q == S_DECODE) begin
      a_q      <= rs1_val;
      b_q      <= rs2_val;
      target_q <= pc_q + (is_jal ? imm_j : imm_b);
    end
    if (state_q == S_EXECUTE) alu_q <= alu_res;
    if (state_q == S_MEM)     mdr_q <= dmem[alu_q[DAW+1:2]];
  end

  // reset on the write edge aborts the instruction's side effects
  always_ff @(posedge clk) begin
    if (!reset && rf_we && (rd != 5'd0)) regs[rd] <= rf_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset && dm_we) dmem[alu_q[DAW+1:2]] <= b_q;
  end

  assign pc      = pc_q;
  assign state   = state_q;
  assign halted  = (state_q == S_HALT);
  assign instret = instret_q;

endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Parametrised multi-cycle RISC-V (RV32I subset) datapath, successor to the single-cycle core. It breaks each instruction into FETCH/DECODE/EXECUTE/MEM/WRITEBACK states under one FSM, so the ALU and memories are reused across cycles, and the register width and memory depths are generic. It adds `bne`, `jal` and a halt state, plus a retired-instruction counter. Benches instantiate it as the top-level core and preload memories hierarchically.

## Interface
- `XLEN`, default 32: datapath and register width; also sets PC and `instret` width.
- `IMEM_DEPTH`, default 256: instruction memory words; power of two.
- `DMEM_DEPTH`, default 256: data memory words; power of two.
- `PC_RESET`, default 0: PC value loaded on reset.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `pc`  out  XLEN  current PC register.
- `state`  out  3  FSM state encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5.
- `halted`  out  1  high while in HALT.
- `instret`  out  XLEN  count of retired instructions.

Internal arrays `imem[IMEM_DEPTH]`, `dmem[DMEM_DEPTH]` and `regs[32]` are each XLEN wide. The bench loads them with `$readmemb`.

## Operation
- Supported instructions:
  - R-type (0110011): add, sub, and, or, slt.
  - addi, andi, ori (0010011).
  - lw (0000011), sw (0100011).
  - beq, bne (1100011).
  - jal (1101111).
  - ecall (0x00000073).
- FETCH: IR <= imem[pc >> 2 mod IMEM_DEPTH]. Address bits [1:0] are ignored.
- DECODE:
  - A <= regs[rs1], B <= regs[rs2].
  - Sign-extended immediate is generated in I/S/B/J format.
  - Target <= pc + imm.
- EXECUTE:
  - ALU-class goes to WRITEBACK.
  - lw/sw compute the address and go to MEM.
  - Branch: compares A and B. pc <= taken ? Target : pc+4, then FETCH.
  - jal: rd <= pc+4, pc <= Target, then FETCH.
  - ecall goes to HALT.
- MEM:
  - sw: dmem[addr>>2 mod DMEM_DEPTH] <= B, pc <= pc+4, then FETCH.
  - lw: MDR <= dmem[...], then WRITEBACK.
- WRITEBACK: rd <= ALU result or MDR, pc <= pc+4, then FETCH.
- HALT: absorbing; only reset leaves it. pc and instret are frozen.
- x0 always reads 0; writes to x0 are discarded.
- Arithmetic wraps modulo 2^XLEN. slt is signed. Shifts are not supported.
- Unknown opcode: handled per `HALT_ON_ILLEGAL_EN`.

## Timing
- CPI by class:
  - ALU/imm: 4 (F,D,E,WB).
  - lw: 5.
  - sw: 4 (F,D,E,M).
  - beq/bne/jal: 3 (F,D,E).
  - ecall: 3 cycles to reach HALT.
- Reset values: pc=PC_RESET, state=FETCH, halted=0, instret=0.
- Register and memory contents are not cleared by reset.
- instret increments on the same edge the PC updates for a retiring instruction. ecall does not count.
- Register file writes take effect at the edge ending WRITEBACK or EXECUTE (jal). They are visible to the next instruction's DECODE.
- Reset mid-instruction aborts it:
  - no register or memory write occurs on that edge;
  - FETCH begins the cycle after reset deasserts.
- PC beyond IMEM_DEPTH*4 wraps modulo the depth. Data addresses wrap modulo DMEM_DEPTH.
- Branch to self is legal and loops indefinitely.

## Configuration
- `HALT_ON_ILLEGAL_EN` defined: an unknown opcode in DECODE sends the FSM to HALT.
  - halted=1, pc holds the illegal instruction's address, instret unchanged.
- Undefined: an unknown opcode is a NOP.
  - pc <= pc+4 at end of DECODE (2 cycles), instret increments.

## Test plan
- Reset, then check outputs. imem[0]=addi x1,x0,5; imem[1]=ecall:
  - pc=0, state=0 after reset;
  - x1=5, instret=1, halted=1 at cycle 7.
- add/sub/slt/and/or on x2=7, x3=-3 (XLEN=32):
  - add = 4, sub = 10, slt x2<x3 = 0, slt x3<x2 = 1;
  - each takes exactly 4 cycles.
- Memory: sw x2,8(x0) then lw x4,8(x0):
  - dmem[2]=7, x4=7;
  - 9 cycles total; instret=2.
- Control flow: beq taken (x1==x1, offset -4) loops; bne not taken falls through; jal x1,+8:
  - x1 = pc+4, next fetched pc = old pc+8;
  - each takes 3 cycles.
- Assert reset during MEM of a sw to address 12: dmem[3] is unchanged, pc=0, instret=0.
- Illegal opcode 0x0000007F at pc=8:
  - with `HALT_ON_ILLEGAL_EN`: halted=1, pc=8.
  - without: pc advances to 12 after 2 cycles and instret increments.
- Also run XLEN=64, IMEM_DEPTH=16: an instruction at pc=64 fetches imem[0].
